// File: rtl/mux_pkg.sv
// mux_pkg: mode constants and the round-robin pick helper shared by stream arbiters
package mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  localparam int MAX_CH = 32;
  typedef struct packed {
    logic [4:0] idx;
    logic found;
  } pick_t;
  // Scans downward in offset so the first valid channel at or after ptr wins last
  function automatic pick_t rr_pick(input logic [MAX_CH-1:0] valid, input logic [4:0] ptr, input int n);
    pick_t p;
    logic [5:0] c;
    p = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      c = 6'(ptr) + 6'(i);
      if (c >= 6'(n)) c = c - 6'(n);
      if (i < n && valid[c[4:0]]) begin
        p.idx = c[4:0];
        p.found = 1'b1;
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting the search at ptr
module rr_arbiter import mux_pkg::*; #(
  parameter int N = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            grantValid
);
  pick_t pick;
  logic unusedIdx;
  always_comb pick = rr_pick(MAX_CH'(valid), 5'(ptr), N);
  assign grant = pick.idx[SELW-1:0];
  assign grantValid = pick.found;
  assign unusedIdx = ^pick.idx;
endmodule

// File: rtl/mux_stream_nto1.sv
// mux_stream_nto1: N-to-1 stream mux with registered output, fixed or round-robin select
module mux_stream_nto1 import mux_pkg::*; #(
  parameter int WIDTH = 64,
  parameter int N = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 rr_mode,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_err
);
  localparam int NP = 1 << SELW;
  logic [NP-1:0] validPad;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] rrGrant;
  logic [SELW-1:0] grant;
  logic rrValid;
  logic grantValid;
  logic selOob;
  logic load;
  logic [WIDTH-1:0] chData [N];
  rr_arbiter #(.N(N), .SELW(SELW)) arb (
    .valid(in_valid),
    .ptr(ptr),
    .grant(rrGrant),
    .grantValid(rrValid)
  );
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign chData[i] = in_data[i*WIDTH +: WIDTH];
  end
  // Padding in_valid lets an out-of-range sel index safely when N is not a power of 2
  always_comb begin
    validPad = NP'(in_valid);
    selOob = 32'(sel) >= N;
    grant = (rr_mode == MODE_RR) ? rrGrant : sel;
    grantValid = (rr_mode == MODE_RR) ? rrValid : !selOob && validPad[sel];
    load = grantValid && (!out_valid || out_ready) && !rst;
    in_ready = load ? N'(1) << grant : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      sel_err <= 1'b0;
      ptr <= '0;
    end else begin
      sel_err <= rr_mode == MODE_FIXED && selOob;
      if (load) begin
        out_valid <= 1'b1;
        out_data <= chData[grant];
        out_chan <= grant;
        if (rr_mode == MODE_RR) ptr <= (grant == SELW'(N - 1)) ? '0 : grant + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_stream_nto1.sv
// tb_mux_stream_nto1: directed and sweep checks of mux_stream_nto1 against a behavioural model
module tb_mux_stream_nto1;
  localparam int N = 8;
  localparam int W = 64;
  localparam int N6 = 6;
  localparam int W6 = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*W-1:0] inData = '0;
  logic [N-1:0] inValid = '0;
  logic [N-1:0] inReady;
  logic [2:0] sel = '0;
  logic rrMode = 1'b0;
  logic outReady = 1'b0;
  logic [W-1:0] outData;
  logic [2:0] outChan;
  logic outValid;
  logic selErr;
  logic [N6*W6-1:0] inData6 = '0;
  logic [N6-1:0] inValid6 = '0;
  logic [N6-1:0] inReady6;
  logic [2:0] sel6 = '0;
  logic outReady6 = 1'b0;
  logic [W6-1:0] outData6;
  logic [2:0] outChan6;
  logic outValid6;
  logic selErr6;
  int nChecks = 0;
  int nFail = 0;
  logic started = 1'b0;

  mux_stream_nto1 #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_ready(inReady),
    .sel(sel), .rr_mode(rrMode), .out_data(outData), .out_chan(outChan),
    .out_valid(outValid), .out_ready(outReady), .sel_err(selErr)
  );
  mux_stream_nto1 #(.WIDTH(W6), .N(N6)) dut6 (
    .clk(clk), .rst(rst), .in_data(inData6), .in_valid(inValid6), .in_ready(inReady6),
    .sel(sel6), .rr_mode(1'b0), .out_data(outData6), .out_chan(outChan6),
    .out_valid(outValid6), .out_ready(outReady6), .sel_err(selErr6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: grant by modular scan, one-deep output slot
  function automatic int grantOf(input logic rr, input logic [2:0] s, input logic [N-1:0] v, input int p);
    if (!rr) return (int'(s) < N && v[s]) ? int'(s) : -1;
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  logic mValid = 1'b0;
  logic [W-1:0] mData = '0;
  int mChan = 0;
  int mPtr = 0;
  logic mErr = 1'b0;
  int mG;
  logic mLoad;
  logic [N-1:0] mReady;

  always_comb begin
    mG = grantOf(rrMode, sel, inValid, mPtr);
    mLoad = mG >= 0 && (!mValid || outReady) && !rst;
    mReady = mLoad ? N'(1) << mG : '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      mValid <= 1'b0;
      mData <= '0;
      mChan <= 0;
      mPtr <= 0;
      mErr <= 1'b0;
    end else begin
      mErr <= !rrMode && int'(sel) >= N;
      if (mLoad) begin
        mValid <= 1'b1;
        mData <= inData[mG*W +: W];
        mChan <= mG;
        if (rrMode) mPtr <= (mG + 1) % N;
      end else if (outReady) begin
        mValid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model in_ready", 64'(inReady), 64'(mReady));
      chk("model out_valid", 64'(outValid), 64'(mValid));
      chk("model sel_err", 64'(selErr), 64'(mErr));
      if (mValid) begin
        chk("model out_data", outData, mData);
        chk("model out_chan", 64'(outChan), 64'(mChan[2:0]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int expRr [4];
    logic [W-1:0] prev;
    expRr = '{7, 2, 7, 2};
    rst = 1'b1;
    inValid = '1;
    outReady = 1'b1;
    inValid6 = '1;
    outReady6 = 1'b1;
    for (int c = 0; c < N6; c++) inData6[c*W6 +: W6] = 16'hC0C0 + 16'(c);
    tick;
    started = 1'b1;
    neg;
    chk("reset out_valid", 64'(outValid), 64'd0);
    chk("reset out_data", outData, 64'd0);
    chk("reset out_chan", 64'(outChan), 64'd0);
    chk("reset sel_err", 64'(selErr), 64'd0);
    chk("reset in_ready", 64'(inReady), 64'd0);
    chk("reset n6 out_valid", 64'(outValid6), 64'd0);
    // Out-of-range select on a 6-channel instance
    tick;
    rst = 1'b0;
    inValid = '0;
    sel6 = 3'd7;
    neg;
    chk("n6 oob in_ready", 64'(inReady6), 64'd0);
    tick;
    sel6 = 3'd2;
    neg;
    chk("n6 sel_err pulse", 64'(selErr6), 64'd1);
    chk("n6 oob no out", 64'(outValid6), 64'd0);
    tick;
    neg;
    chk("n6 sel_err clears", 64'(selErr6), 64'd0);
    chk("n6 valid after", 64'(outValid6), 64'd1);
    chk("n6 chan", 64'(outChan6), 64'd2);
    chk("n6 data", 64'(outData6), 64'h0000_0000_0000_C0C2);
    // Fixed mode single transfer
    tick;
    rrMode = 1'b0;
    sel = 3'd3;
    inValid = 8'h08;
    inData[3*W +: W] = 64'hDEADBEEF_00000003;
    outReady = 1'b1;
    neg;
    chk("fixed in_ready", 64'(inReady), 64'h08);
    tick;
    inValid = '0;
    neg;
    chk("fixed out_valid", 64'(outValid), 64'd1);
    chk("fixed out_data", outData, 64'hDEADBEEF_00000003);
    chk("fixed out_chan", 64'(outChan), 64'd3);
    // Backpressure then drain-and-reload
    tick;
    inValid = 8'h08;
    inData[3*W +: W] = 64'h0000_0000_AAAA_0001;
    tick;
    outReady = 1'b0;
    inData[3*W +: W] = 64'h0000_0000_AAAA_0002;
    for (int k = 0; k < 4; k++) begin
      neg;
      chk("bp in_ready", 64'(inReady), 64'd0);
      chk("bp out_data", outData, 64'h0000_0000_AAAA_0001);
      chk("bp out_valid", 64'(outValid), 64'd1);
      tick;
    end
    outReady = 1'b1;
    neg;
    chk("drain in_ready", 64'(inReady), 64'h08);
    tick;
    neg;
    chk("no bubble valid", 64'(outValid), 64'd1);
    chk("no bubble data", outData, 64'h0000_0000_AAAA_0002);
    // Round-robin over all channels, then a sparse pattern from ptr=3
    tick;
    rrMode = 1'b1;
    inValid = 8'hFF;
    for (int c = 0; c < N; c++) inData[c*W +: W] = {32'hC0DE0000, 32'(c)};
    for (int k = 0; k < 11; k++) begin
      tick;
      if (k == 10) inValid = 8'b1000_0100;
      neg;
      chk("rr all chan", 64'(outChan), 64'(k % 8));
    end
    for (int j = 0; j < 4; j++) begin
      tick;
      if (j == 3) begin
        outReady = 1'b0;
        inValid = 8'b0010_0100;
      end
      neg;
      chk("rr sparse chan", 64'(outChan), 64'(expRr[j]));
    end
    // Reset while a word is stalled; pointer must return to 0
    tick;
    rst = 1'b1;
    neg;
    chk("hold before reset", 64'(outValid), 64'd1);
    tick;
    rst = 1'b0;
    outReady = 1'b1;
    neg;
    chk("midrst out_valid", 64'(outValid), 64'd0);
    chk("midrst out_data", outData, 64'd0);
    chk("midrst grant lowest", 64'(inReady), 64'h04);
    tick;
    neg;
    chk("midrst first chan", 64'(outChan), 64'd2);
    chk("midrst first valid", 64'(outValid), 64'd1);
    // Random fixed-select sweep against a plain 8:1 reference mux
    tick;
    rrMode = 1'b0;
    inValid = '1;
    outReady = 1'b1;
    sel = 3'($urandom_range(0, 7));
    for (int c = 0; c < N; c++) inData[c*W +: W] = {$urandom, $urandom};
    prev = inData[sel*W +: W];
    for (int i = 0; i < 10000; i++) begin
      tick;
      chk("sweep out_data", outData, prev);
      sel = 3'($urandom_range(0, 7));
      for (int c = 0; c < N; c++) inData[c*W +: W] = {$urandom, $urandom};
      prev = inData[sel*W +: W];
    end
    neg;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
